// File: rtl/key_toggle_pulser.sv
// Pushbutton conditioner: two-flop synchroniser, counting debouncer and a small
// FSM that turns accepted presses (plus optional auto-repeat) into one-cycle toggle pulses.
//
// state  | meaning
// IDLE   | waiting for an accepted press
// HOLD   | key held after the press pulse, counting down to the first repeat
// REPEAT | key still held, emitting a pulse every REPEAT_CYCLES
module key_toggle_pulser #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       t_pulse,
    output logic       btn_level,
    output logic [7:0] pulse_count
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic             RAW_IDLE    = BTN_ACTIVE_LOW;
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [1:0]       sync_q;
    logic             sample;
    logic [DB_W-1:0]  db_cnt;
    logic             differs;
    logic             accept;
    logic             rise;
    logic             fall;
    logic [TMR_W-1:0] timer;
    state_t           state;

    // Flops reset to the released level so a key held through reset reads as a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {RAW_IDLE, RAW_IDLE};
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign sample  = BTN_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
    assign differs = (sample != btn_level);
    assign accept  = differs && (db_cnt == DB_LAST);
    assign rise    = accept && !btn_level;
    assign fall    = accept && btn_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else if (!differs) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            btn_level <= ~btn_level;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Edge events are taken from the debouncer's accept condition so the pulse
    // registers on the same edge that btn_level changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timer       <= '0;
            t_pulse     <= 1'b0;
            pulse_count <= '0;
        end else begin
            t_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        t_pulse     <= 1'b1;
                        pulse_count <= pulse_count + 8'd1;
                        timer       <= REPEAT_EN ? HOLD_LOAD : '0;
                        state       <= REPEAT_EN ? HOLD : IDLE;
                    end
                end
                HOLD, REPEAT: begin
                    // Release takes priority over a repeat due on the same edge.
                    if (fall) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == '0) begin
                        t_pulse     <= 1'b1;
                        pulse_count <= pulse_count + 8'd1;
                        timer       <= REPEAT_LOAD;
                        state       <= REPEAT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_toggle_pulser.sv
// Directed bench for key_toggle_pulser: one instance without and one with auto-repeat,
// both fed the same key; each scenario task checks its own hand-computed edge timing.
module tb_key_toggle_pulser;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_raw = 1'b1;
    logic       t_pulse, btn_level;
    logic [7:0] pulse_count;
    logic       t_pulse_r, btn_level_r;
    logic [7:0] pulse_count_r;

    int checks = 0;
    int passed = 0;

    key_toggle_pulser #(
        .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1), .REPEAT_EN(1'b0),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .t_pulse(t_pulse), .btn_level(btn_level), .pulse_count(pulse_count)
    );

    key_toggle_pulser #(
        .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut_rep (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .t_pulse(t_pulse_r), .btn_level(btn_level_r), .pulse_count(pulse_count_r)
    );

    always #5 clk = ~clk;

    // After step(), the bench sits 1 time unit past the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        btn_raw = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b0;
        btn_raw = 1'b1;
        repeat (3) step();
        checks++;
        if ({t_pulse, btn_level, pulse_count} !== 10'd0)
            $display("FAIL reset_outputs: got tp=%b lvl=%b cnt=%0d required all 0", t_pulse, btn_level, pulse_count);
        else passed++;
        checks++;
        if ({t_pulse_r, btn_level_r, pulse_count_r} !== 10'd0)
            $display("FAIL reset_outputs_rep: got tp=%b lvl=%b cnt=%0d required all 0", t_pulse_r, btn_level_r, pulse_count_r);
        else passed++;
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (t_pulse || t_pulse_r) seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL reset_idle_pulses: got %0d required 0", seen);
        else passed++;
        checks++;
        if (pulse_count !== 8'd0 || btn_level !== 1'b0)
            $display("FAIL reset_idle_state: got cnt=%0d lvl=%b required 0/0", pulse_count, btn_level);
        else passed++;
    endtask

    task automatic test_clean_press();
        logic [63:0] mask;
        logic        lvl5, lvl6;
        apply_reset();
        btn_raw = 1'b0;
        mask = '0;
        lvl5 = 1'bx;
        lvl6 = 1'bx;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (t_pulse) mask[e] = 1'b1;
            if (e == 5) lvl5 = btn_level;
            if (e == 6) lvl6 = btn_level;
        end
        checks++;
        if (mask !== 64'h40) $display("FAIL press_pulse_edges: got %h required %h", mask, 64'h40);
        else passed++;
        checks++;
        if (lvl5 !== 1'b0 || lvl6 !== 1'b1)
            $display("FAIL press_level: got E5=%b E6=%b required 0/1", lvl5, lvl6);
        else passed++;
        checks++;
        if (pulse_count !== 8'd1) $display("FAIL press_count: got %0d required 1", pulse_count);
        else passed++;

        btn_raw = 1'b1;
        mask = '0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (t_pulse) mask[e] = 1'b1;
            if (e == 5) lvl5 = btn_level;
            if (e == 6) lvl6 = btn_level;
        end
        checks++;
        if (lvl5 !== 1'b1 || lvl6 !== 1'b0)
            $display("FAIL release_level: got E5=%b E6=%b required 1/0", lvl5, lvl6);
        else passed++;
        checks++;
        if (mask !== 64'h0 || pulse_count !== 8'd1)
            $display("FAIL release_no_pulse: got mask=%h cnt=%0d required 0/1", mask, pulse_count);
        else passed++;
    endtask

    task automatic test_bounce();
        int seen, lvl_seen;
        apply_reset();
        seen = 0;
        lvl_seen = 0;
        for (int i = 0; i < 30; i++) begin
            btn_raw = ((i / 2) % 2) != 0;
            step();
            if (t_pulse || t_pulse_r) seen++;
            if (btn_level || btn_level_r) lvl_seen++;
        end
        btn_raw = 1'b1;
        repeat (10) begin
            step();
            if (t_pulse || t_pulse_r) seen++;
            if (btn_level || btn_level_r) lvl_seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL bounce_pulses: got %0d required 0", seen);
        else passed++;
        checks++;
        if (lvl_seen != 0) $display("FAIL bounce_level: got %0d high cycles required 0", lvl_seen);
        else passed++;
        checks++;
        if (pulse_count !== 8'd0 || pulse_count_r !== 8'd0)
            $display("FAIL bounce_count: got %0d/%0d required 0/0", pulse_count, pulse_count_r);
        else passed++;
    endtask

    task automatic test_auto_repeat();
        logic [63:0] mask_r, mask_n, exp_r;
        logic        lvl30, lvl31;
        apply_reset();
        exp_r = '0;
        exp_r[6] = 1'b1;
        exp_r[16] = 1'b1;
        exp_r[21] = 1'b1;
        exp_r[26] = 1'b1;
        mask_r = '0;
        mask_n = '0;
        lvl30 = 1'bx;
        lvl31 = 1'bx;
        btn_raw = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            if (e == 26) btn_raw = 1'b1;
            step();
            if (t_pulse_r) mask_r[e] = 1'b1;
            if (t_pulse) mask_n[e] = 1'b1;
            if (e == 30) lvl30 = btn_level_r;
            if (e == 31) lvl31 = btn_level_r;
        end
        checks++;
        if (mask_r !== exp_r) $display("FAIL repeat_edges: got %h required %h", mask_r, exp_r);
        else passed++;
        checks++;
        if (lvl30 !== 1'b1 || lvl31 !== 1'b0)
            $display("FAIL repeat_release_level: got E30=%b E31=%b required 1/0", lvl30, lvl31);
        else passed++;
        checks++;
        if (pulse_count_r !== 8'd4) $display("FAIL repeat_count: got %0d required 4", pulse_count_r);
        else passed++;
        checks++;
        if (mask_n !== 64'h40) $display("FAIL no_repeat_held: got %h required %h", mask_n, 64'h40);
        else passed++;

        mask_r = '0;
        btn_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (t_pulse_r) mask_r[e] = 1'b1;
        end
        checks++;
        if (mask_r !== 64'h40 || pulse_count_r !== 8'd5)
            $display("FAIL repeat_repress: got mask=%h cnt=%0d required %h/5", mask_r, pulse_count_r, 64'h40);
        else passed++;
        btn_raw = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset_mid_debounce();
        logic [63:0] mask, mask_r;
        int          seen;
        apply_reset();
        seen = 0;
        btn_raw = 1'b0;
        repeat (3) begin
            step();
            if (t_pulse || t_pulse_r) seen++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (btn_level !== 1'b0 || pulse_count !== 8'd0)
            $display("FAIL midreset_async: got lvl=%b cnt=%0d required 0/0", btn_level, pulse_count);
        else passed++;
        repeat (2) begin
            step();
            if (t_pulse || t_pulse_r) seen++;
        end
        rst = 1'b1;
        mask = '0;
        mask_r = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (t_pulse) mask[k] = 1'b1;
            if (t_pulse_r) mask_r[k] = 1'b1;
        end
        checks++;
        if (seen != 0) $display("FAIL midreset_no_pulse: got %0d required 0", seen);
        else passed++;
        checks++;
        if (mask !== 64'h40 || mask_r !== 64'h40)
            $display("FAIL midreset_repress: got %h/%h required %h", mask, mask_r, 64'h40);
        else passed++;
        checks++;
        if (pulse_count !== 8'd1) $display("FAIL midreset_count: got %0d required 1", pulse_count);
        else passed++;
        btn_raw = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_counter_wrap();
        int         miss;
        logic [7:0] c255, c256;
        apply_reset();
        miss = 0;
        c255 = 8'hxx;
        c256 = 8'hxx;
        for (int p = 1; p <= 257; p++) begin
            btn_raw = 1'b0;
            for (int s = 1; s <= 8; s++) begin
                step();
                if (s == 6) begin
                    if (!t_pulse) miss++;
                    if (p == 255) c255 = pulse_count;
                    if (p == 256) c256 = pulse_count;
                end else if (t_pulse) begin
                    miss++;
                end
            end
            btn_raw = 1'b1;
            for (int s = 1; s <= 8; s++) begin
                step();
                if (t_pulse) miss++;
            end
        end
        checks++;
        if (miss != 0) $display("FAIL wrap_pulse_timing: got %0d misplaced pulses required 0", miss);
        else passed++;
        checks++;
        if (c255 !== 8'd255) $display("FAIL wrap_255: got %0d required 255", c255);
        else passed++;
        checks++;
        if (c256 !== 8'd0) $display("FAIL wrap_256: got %0d required 0", c256);
        else passed++;
        checks++;
        if (pulse_count !== 8'd1) $display("FAIL wrap_final: got %0d required 1", pulse_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_reset_mid_debounce();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
